// File: rtl/arch_map_table_pkg.sv
// Shared sizing, state encoding and packet types for the retirement map table.
package arch_map_table_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int TAG_W     = $clog2(PHYS_REGS);
    localparam int LANES     = 4;

    localparam int ARCH_W    = $clog2(ARCH_REGS);
    localparam int LANE_W    = $clog2(LANES);
    localparam int GROUPS    = ARCH_REGS / LANES;
    localparam int GROUP_W   = ARCH_W - LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } amt_state_e;

    typedef struct packed {
        logic              retire_en;
        logic [ARCH_W-1:0] retire_arch;
        logic [TAG_W-1:0]  retire_phys;
    } ir_amt_packet_t;

    typedef struct packed {
        logic             free_en;
        logic [TAG_W-1:0] free_tag;
    } amt_fl_packet_t;

    typedef struct packed {
        logic                         valid;
        logic [ARCH_W-1:0]            base;
        logic [LANES-1:0][TAG_W-1:0]  tags;
        logic                         done;
    } amt_mt_recover_packet_t;

endpackage

// File: rtl/arch_map_table.sv
// Retirement map table: holds the committed arch-to-phys mapping, releases
// displaced tags to the free list and streams the map out on recovery.
module arch_map_table
    import arch_map_table_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     retire_en,
    input  logic [ARCH_W-1:0]        retire_arch,
    input  logic [TAG_W-1:0]         retire_phys,
    output logic                     free_en,
    output logic [TAG_W-1:0]         free_tag,
    input  logic                     recover_req,
    output logic                     recover_busy,
    output logic                     recover_valid,
    output logic [ARCH_W-1:0]        recover_base,
    output logic [LANES*TAG_W-1:0]   recover_tags,
    output logic                     recover_done
);

    logic [TAG_W-1:0]   entry_q [ARCH_REGS];
    logic [TAG_W-1:0]   entry_d [ARCH_REGS];
    logic               free_en_q;
    logic               free_en_d;
    logic [TAG_W-1:0]   free_tag_q;
    logic [TAG_W-1:0]   free_tag_d;
    amt_state_e         state_q;
    amt_state_e         state_d;
    logic [GROUP_W-1:0] group_q;
    logic [GROUP_W-1:0] group_d;
    logic               retire_write;
    logic [ARCH_W-1:0]  stream_base;

    // Arch reg 0 is hardwired: it is never written, so it keeps its reset value of 0.
    assign retire_write = retire_en && (retire_arch != '0);
    assign stream_base  = {group_q, LANE_W'(0)};

    // Commit the retiring tag and capture the tag it displaces for release.
    always_comb begin
        entry_d    = entry_q;
        free_en_d  = 1'b0;
        free_tag_d = free_tag_q;
        if (retire_write) begin
            entry_d[retire_arch] = retire_phys;
            free_en_d            = 1'b1;
            free_tag_d           = entry_q[retire_arch];
        end
    end

    // Table and free-event registers; reset restores the identity mapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                entry_q[i] <= TAG_W'(i);
            end
            free_en_q  <= 1'b0;
            free_tag_q <= '0;
        end else begin
            entry_q    <= entry_d;
            free_en_q  <= free_en_d;
            free_tag_q <= free_tag_d;
        end
    end

    // Recovery FSM state and group counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            group_q <= '0;
        end else begin
            state_q <= state_d;
            group_q <= group_d;
        end
    end

    // Next-state: a request is only honoured from IDLE, so a re-pulse mid-stream is ignored.
    always_comb begin
        state_d = state_q;
        group_d = group_q;
        case (state_q)
            ST_IDLE: begin
                if (recover_req) begin
                    state_d = ST_STREAM;
                    group_d = '0;
                end
            end
            ST_STREAM: begin
                if (group_q < GROUP_W'(GROUPS - 1)) begin
                    group_d = group_q + GROUP_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                group_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                group_d = '0;
            end
        endcase
    end

    // Stream outputs read the registered table, so a same-edge retire shows up a cycle later.
    always_comb begin
        recover_valid = 1'b0;
        recover_busy  = 1'b0;
        recover_done  = 1'b0;
        recover_base  = '0;
        recover_tags  = '0;
        case (state_q)
            ST_STREAM: begin
                recover_valid = 1'b1;
                recover_busy  = 1'b1;
                recover_base  = stream_base;
                for (int k = 0; k < LANES; k++) begin
                    recover_tags[k*TAG_W +: TAG_W] = entry_q[stream_base + ARCH_W'(k)];
                end
            end
            ST_DONE: begin
                recover_busy = 1'b1;
                recover_done = 1'b1;
            end
            default: begin
                recover_valid = 1'b0;
            end
        endcase
    end

    assign free_en  = free_en_q;
    assign free_tag = free_tag_q;

endmodule

// File: tb/tb_arch_map_table.sv
// Self-checking bench for arch_map_table: directed scenarios plus a randomized
// run, all compared against a cycle-indexed behavioural model of the map.
module tb_arch_map_table;

    localparam int NREG = 32;
    localparam int NLN  = 4;
    localparam int NGRP = NREG / NLN;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        retire_en = 1'b0;
    logic [4:0]  retire_arch = '0;
    logic [5:0]  retire_phys = '0;
    logic        free_en;
    logic [5:0]  free_tag;
    logic        recover_req = 1'b0;
    logic        recover_busy;
    logic        recover_valid;
    logic [4:0]  recover_base;
    logic [23:0] recover_tags;
    logic        recover_done;

    int checks = 0;
    int failures = 0;

    // Model state: the map, the last free event, and the edge number at which a recovery began.
    int mdl_map [NREG];
    bit mdl_free_en;
    int mdl_free_tag;
    bit mdl_active;
    int mdl_start;
    int cyc = 0;

    arch_map_table dut (
        .clock        (clock),
        .reset        (reset),
        .retire_en    (retire_en),
        .retire_arch  (retire_arch),
        .retire_phys  (retire_phys),
        .free_en      (free_en),
        .free_tag     (free_tag),
        .recover_req  (recover_req),
        .recover_busy (recover_busy),
        .recover_valid(recover_valid),
        .recover_base (recover_base),
        .recover_tags (recover_tags),
        .recover_done (recover_done)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    function automatic int mdl_off();
        return mdl_active ? (cyc - mdl_start) : -1;
    endfunction

    function automatic bit exp_valid();
        int o = mdl_off();
        return (o >= 0) && (o < NGRP);
    endfunction

    function automatic bit exp_done();
        return mdl_off() == NGRP;
    endfunction

    function automatic bit exp_busy();
        int o = mdl_off();
        return (o >= 0) && (o <= NGRP);
    endfunction

    function automatic int exp_base();
        return exp_valid() ? mdl_off() * NLN : 0;
    endfunction

    function automatic logic [23:0] exp_tags();
        logic [23:0] t = '0;
        int b;
        if (exp_valid()) begin
            b = exp_base();
            for (int k = 0; k < NLN; k++) t[k*6 +: 6] = 6'(mdl_map[b + k]);
        end
        return t;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NREG; i++) mdl_map[i] = i;
        mdl_free_en  = 1'b0;
        mdl_free_tag = 0;
        mdl_active   = 1'b0;
        mdl_start    = 0;
    endtask

    // Model update for one rising edge, using the inputs held across that edge.
    task automatic mdl_edge();
        bit was_busy;
        if (!reset) begin
            mdl_reset();
            cyc++;
            return;
        end
        was_busy = exp_busy();
        if (retire_en && retire_arch != 5'd0) begin
            mdl_free_tag = mdl_map[retire_arch];
            mdl_map[retire_arch] = retire_phys;
            mdl_free_en = 1'b1;
        end else begin
            mdl_free_en = 1'b0;
        end
        cyc++;
        if (recover_req && !was_busy) begin
            mdl_active = 1'b1;
            mdl_start  = cyc;
        end
    endtask

    task automatic drive(input logic en, input logic [4:0] arch, input logic [5:0] phys, input logic req);
        retire_en   = en;
        retire_arch = arch;
        retire_phys = phys;
        recover_req = req;
    endtask

    // One clock: model follows the edge, outputs are then sampled 1 ns later.
    task automatic tick();
        @(posedge clock);
        mdl_edge();
        #1;
    endtask

    task automatic reset_dut();
        drive(1'b0, 5'd0, 6'd0, 1'b0);
        reset = 1'b0;
        mdl_reset();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({free_en, free_tag, recover_busy, recover_valid, recover_base, recover_tags, recover_done} !== 39'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%0h exp=0",
                     {free_en, free_tag, recover_busy, recover_valid, recover_base, recover_tags, recover_done});
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({free_en, recover_busy, recover_valid, recover_done, recover_base, recover_tags} !== 32'd0) begin
            failures++;
            $display("[TB] FAIL idle_outputs got=%0h exp=0",
                     {free_en, recover_busy, recover_valid, recover_done, recover_base, recover_tags});
        end
        drive(1'b0, 5'd0, 6'd0, 1'b1);
        tick();
        drive(1'b0, 5'd0, 6'd0, 1'b0);
        checks++;
        if ({recover_valid, recover_base, recover_tags} !== {1'b1, 5'd0, 24'h0C2040}) begin
            failures++;
            $display("[TB] FAIL group0_identity valid=%0b base=%0d tags=%06h exp tags=0c2040",
                     recover_valid, recover_base, recover_tags);
        end
        repeat (NGRP + 1) tick();
        checks++;
        if (recover_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_after_recovery got=%0b exp=0", recover_busy);
        end
    endtask

    task automatic test_retire();
        drive(1'b1, 5'd3, 6'd40, 1'b0);
        tick();
        checks++;
        if ({free_en, free_tag} !== {1'b1, 6'd3}) begin
            failures++;
            $display("[TB] FAIL retire_first got en=%0b tag=%0d exp en=1 tag=3", free_en, free_tag);
        end
        drive(1'b1, 5'd3, 6'd41, 1'b0);
        tick();
        checks++;
        if ({free_en, free_tag} !== {1'b1, 6'd40}) begin
            failures++;
            $display("[TB] FAIL retire_back_to_back got en=%0b tag=%0d exp en=1 tag=40", free_en, free_tag);
        end
        drive(1'b0, 5'd9, 6'd9, 1'b0);
        tick();
        checks++;
        if ({free_en, free_tag} !== {1'b0, 6'd40}) begin
            failures++;
            $display("[TB] FAIL retire_idle_hold got en=%0b tag=%0d exp en=0 tag=40", free_en, free_tag);
        end
    endtask

    task automatic test_arch_zero();
        drive(1'b1, 5'd0, 6'd50, 1'b0);
        tick();
        checks++;
        if ({free_en, free_tag} !== {1'b0, 6'd40}) begin
            failures++;
            $display("[TB] FAIL arch0_no_free got en=%0b tag=%0d exp en=0 tag=40", free_en, free_tag);
        end
        drive(1'b0, 5'd0, 6'd0, 1'b1);
        tick();
        drive(1'b0, 5'd0, 6'd0, 1'b0);
        checks++;
        if (recover_tags !== {6'd41, 6'd2, 6'd1, 6'd0}) begin
            failures++;
            $display("[TB] FAIL arch0_entry got=%06h exp=%06h", recover_tags, {6'd41, 6'd2, 6'd1, 6'd0});
        end
        repeat (NGRP + 1) tick();
    endtask

    task automatic test_stream();
        int groups = 0;
        int dones = 0;
        reset_dut();
        drive(1'b1, 5'd5, 6'd45, 1'b0);
        tick();
        drive(1'b0, 5'd0, 6'd0, 1'b1);
        tick();
        drive(1'b0, 5'd0, 6'd0, 1'b0);
        for (int i = 0; i < NGRP + 2; i++) begin
            checks++;
            if ({recover_valid, recover_busy, recover_done} !== {exp_valid(), exp_busy(), exp_done()}) begin
                failures++;
                $display("[TB] FAIL stream_flags cyc=%0d got=%03b exp=%03b", i,
                         {recover_valid, recover_busy, recover_done}, {exp_valid(), exp_busy(), exp_done()});
            end
            checks++;
            if ({recover_base, recover_tags} !== {5'(exp_base()), exp_tags()}) begin
                failures++;
                $display("[TB] FAIL stream_data cyc=%0d got base=%0d tags=%06h exp base=%0d tags=%06h",
                         i, recover_base, recover_tags, exp_base(), exp_tags());
            end
            if (recover_valid === 1'b1 && recover_base === 5'd4) begin
                checks++;
                if (recover_tags[11:6] !== 6'd45) begin
                    failures++;
                    $display("[TB] FAIL group1_lane1 got=%0d exp=45", recover_tags[11:6]);
                end
            end
            if (recover_valid === 1'b1) groups++;
            if (recover_done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (groups != NGRP || dones != 1) begin
            failures++;
            $display("[TB] FAIL stream_counts got groups=%0d dones=%0d exp groups=8 dones=1", groups, dones);
        end
    endtask

    task automatic test_retire_during_stream();
        int groups = 0;
        reset_dut();
        drive(1'b0, 5'd0, 6'd0, 1'b1);
        tick();
        for (int i = 0; i < NGRP + 2; i++) begin
            checks++;
            if ({recover_valid, recover_done, recover_base, recover_tags} !==
                {exp_valid(), exp_done(), 5'(exp_base()), exp_tags()}) begin
                failures++;
                $display("[TB] FAIL midstream_retire cyc=%0d got v=%0b d=%0b base=%0d tags=%06h exp v=%0b d=%0b base=%0d tags=%06h",
                         i, recover_valid, recover_done, recover_base, recover_tags,
                         exp_valid(), exp_done(), exp_base(), exp_tags());
            end
            if (i == 5) begin
                checks++;
                if ({recover_base, recover_tags[5:0]} !== {5'd20, 6'd61}) begin
                    failures++;
                    $display("[TB] FAIL group5_lane0 got base=%0d tag=%0d exp base=20 tag=61",
                             recover_base, recover_tags[5:0]);
                end
            end
            if (recover_valid === 1'b1) groups++;
            if (i == 2)      drive(1'b1, 5'd2, 6'd60, 1'b1);
            else if (i == 3) drive(1'b1, 5'd20, 6'd61, 1'b0);
            else             drive(1'b0, 5'd0, 6'd0, 1'b0);
            tick();
        end
        checks++;
        if (groups != NGRP) begin
            failures++;
            $display("[TB] FAIL midstream_group_count got=%0d exp=8", groups);
        end
    endtask

    task automatic test_reset_mid_stream();
        reset_dut();
        drive(1'b1, 5'd7, 6'd33, 1'b0);
        tick();
        drive(1'b0, 5'd0, 6'd0, 1'b1);
        tick();
        drive(1'b0, 5'd0, 6'd0, 1'b0);
        repeat (3) tick();
        checks++;
        if (recover_base !== 5'd12) begin
            failures++;
            $display("[TB] FAIL base_before_reset got=%0d exp=12", recover_base);
        end
        #2;
        reset = 1'b0;
        mdl_reset();
        #1;
        checks++;
        if ({free_en, free_tag, recover_busy, recover_valid, recover_base, recover_tags, recover_done} !== 39'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_outputs got=%0h exp=0",
                     {free_en, free_tag, recover_busy, recover_valid, recover_base, recover_tags, recover_done});
        end
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({recover_done, recover_busy} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL no_done_after_reset cyc=%0d got done=%0b busy=%0b exp 0 0",
                         i, recover_done, recover_busy);
            end
            tick();
        end
        drive(1'b0, 5'd0, 6'd0, 1'b1);
        tick();
        drive(1'b0, 5'd0, 6'd0, 1'b0);
        for (int g = 0; g < NGRP; g++) begin
            logic [23:0] ident;
            for (int k = 0; k < NLN; k++) ident[k*6 +: 6] = 6'(g * NLN + k);
            checks++;
            if ({recover_valid, recover_base, recover_tags} !== {1'b1, 5'(g * NLN), ident}) begin
                failures++;
                $display("[TB] FAIL identity_after_reset group=%0d got v=%0b base=%0d tags=%06h exp tags=%06h",
                         g, recover_valid, recover_base, recover_tags, ident);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] last_arch = 5'd1;
        logic [4:0] arch;
        for (int i = 0; i < 400; i++) begin
            arch = ($urandom_range(0, 3) == 0) ? last_arch : 5'($urandom_range(0, NREG - 1));
            drive(1'($urandom_range(0, 2) != 0), arch, 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 11) == 0));
            last_arch = arch;
            tick();
            checks++;
            if ({free_en, free_tag} !== {mdl_free_en, 6'(mdl_free_tag)}) begin
                failures++;
                $display("[TB] FAIL random_free cyc=%0d got en=%0b tag=%0d exp en=%0b tag=%0d",
                         i, free_en, free_tag, mdl_free_en, mdl_free_tag);
            end
            checks++;
            if ({recover_valid, recover_busy, recover_done, recover_base, recover_tags} !==
                {exp_valid(), exp_busy(), exp_done(), 5'(exp_base()), exp_tags()}) begin
                failures++;
                $display("[TB] FAIL random_recover cyc=%0d got v=%0b b=%0b d=%0b base=%0d tags=%06h exp v=%0b b=%0b d=%0b base=%0d tags=%06h",
                         i, recover_valid, recover_busy, recover_done, recover_base, recover_tags,
                         exp_valid(), exp_busy(), exp_done(), exp_base(), exp_tags());
            end
        end
    endtask

    initial begin
        mdl_reset();
        $display("[TB] starting arch_map_table bench");
        test_reset();
        test_retire();
        test_arch_zero();
        test_stream();
        test_retire_during_stream();
        test_reset_mid_stream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arch_map_table.md
Name: arch_map_table

Overview:
- Retirement (architectural) map table sitting directly downstream of stage_ir; consumes each retiring instruction's arch-dest/phys-tag pair.
- Holds the committed arch-to-phys mapping and emits the displaced committed tag as a registered free event.
- On a recovery request it streams the committed mapping, LANES entries per cycle, to the speculative map_table through a small FSM.

Parameters:
- ARCH_REGS, 32, number of architectural registers; must be a multiple of LANES.
- PHYS_REGS, 64, number of physical registers.
- TAG_W, 6, physical tag width, equal to clog2(PHYS_REGS).
- LANES, 4, entries streamed per recovery cycle.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- retire_en  in  1  a retirement is presented this cycle.
- retire_arch  in  5  architectural destination of the retiring instruction.
- retire_phys  in  TAG_W  physical tag now committed to retire_arch.
- free_en  out  1  registered; the previous committed tag of retire_arch is released.
- free_tag  out  TAG_W  registered; the released tag.
- recover_req  in  1  single-cycle request to stream the committed map.
- recover_busy  out  1  high in STREAM and DONE.
- recover_valid  out  1  recover_base and recover_tags are meaningful this cycle.
- recover_base  out  5  arch index of lane 0 in the current group.
- recover_tags  out  LANES*TAG_W  tags for arch regs base..base+LANES-1, lane 0 in the LSBs.
- recover_done  out  1  one-cycle pulse after the last group.

Behaviour:
- Reset (reset low, asynchronous):
  - entry[i] = i for every i.
  - FSM = IDLE, group counter = 0.
  - All outputs 0.
- Retire path (every state):
  - On a rising edge with retire_en=1 and retire_arch!=0: entry[retire_arch] <= retire_phys; free_tag <= old entry[retire_arch]; free_en <= 1.
  - retire_arch=0: no table write; free_en <= 0; free_tag holds its value.
  - retire_en=0: free_en <= 0; free_tag holds its value.
  - Free event latency is 1 cycle.
  - Back-to-back retires to the same arch reg: the second frees the tag committed by the first.
- Entry 0 always reads 0.
- FSM states: IDLE, STREAM, DONE.
  - IDLE: recover_req=1 -> STREAM, counter <= 0. Otherwise stay.
  - STREAM: counter < ARCH_REGS/LANES-1 -> counter++ and stay. Otherwise -> DONE.
  - DONE -> IDLE.
- STREAM outputs (combinational from state, counter and table):
  - recover_valid=1, recover_base=counter*LANES.
  - recover_tags = entry[base+k] for lanes k=0..LANES-1, read before any same-edge retire write.
- Recovery timing: recover_req sampled at edge t gives valid groups in the 8 cycles following edge t (defaults), recover_done in the cycle after the last group, then IDLE.
- recover_done=1 only in DONE. recover_busy=1 in STREAM and DONE.
- recover_req while busy: ignored, no restart.
- Retire during STREAM:
  - Applied normally.
  - Groups streamed earlier keep the value already sent.
  - Later groups show the updated value.
- Reset asserted mid-stream: immediate return to IDLE with identity map; no recover_done.
- Outputs other than free_en and free_tag are 0 in IDLE.

Decomposition:
- Shared defines/package (sys_defs.svh) gets:
  - ARCH_REGS, PHYS_REGS, TAG_W, LANES.
  - IR_AMT_PACKET {retire_en, retire_arch, retire_phys}.
  - AMT_FL_PACKET {free_en, free_tag}.
  - AMT_MT_RECOVER_PACKET {valid, base, tags[LANES], done}.
- Top level may expose these packets in place of the loose ports; field semantics stay identical.
- No sub-module: the FSM and counter stay inline; the entry array is a plain register array.

Test Plan:
- Reset then idle 2 cycles -> free_en=0, recover_busy=0, all outputs 0; a recovery then shows group 0 tags {3,2,1,0}.
- Retire (arch 3, phys 40) -> next cycle free_en=1, free_tag=3. Retire (arch 3, phys 41) -> free_tag=40.
- Retire with arch 0, phys 50 -> free_en=0. A following recovery shows entry 0 = 0.
- After retiring arch 5 -> 45, pulse recover_req:
  - 8 consecutive valid cycles with base 0,4,...,28.
  - Group 1 lane 1 = 45; all other lanes identity.
  - recover_done for 1 cycle, then busy=0.
- During STREAM at base=8:
  - Retire arch 2 -> 60: later stream is unchanged for entry 2.
  - Retire arch 20 -> 61: group 5 lane 0 = 61.
  - recover_req re-pulsed mid-stream: ignored, total still 8 groups.
- Assert reset at base=12 -> outputs 0 immediately, no done pulse, table back to identity.
